// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide sequencer for the Execute stage.
// Registered multiplier plus radix-2 restoring divider with stall/cancel.
module mdu_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cancel_i,
    output logic             stall_o,
    output logic             busy_o,
    output logic             ready_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             div_zero_o
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, MUL, DIV_RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             init_q, init_d;
    logic             dz_q, dz_d;

    logic             sgn, a_neg, b_neg;
    logic [WIDTH-1:0] a_abs, b_abs;
    logic [2*WIDTH-1:0] a_ext, b_ext, prod;
    logic [WIDTH:0]   trial;
    logic             qbit;
    logic [WIDTH-1:0] rem_nx, quo_nx;

    assign sgn   = ~op_q[0];
    assign a_neg = sgn & a_q[WIDTH-1];
    assign b_neg = sgn & b_q[WIDTH-1];
    assign a_abs = a_neg ? -a_q : a_q;
    assign b_abs = b_neg ? -b_q : b_q;

    // Low 2W bits of a sign-extended product equal the signed product.
    assign a_ext = {{WIDTH{a_neg}}, a_q};
    assign b_ext = {{WIDTH{b_neg}}, b_q};
    assign prod  = a_ext * b_ext;

    assign trial  = {rem_q, quo_q[WIDTH-1]} - {1'b0, b_abs};
    assign qbit   = ~trial[WIDTH];
    assign rem_nx = qbit ? trial[WIDTH-1:0] : {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
    assign quo_nx = {quo_q[WIDTH-2:0], qbit};

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        init_d  = init_q;
        dz_d    = dz_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    op_d = op_i;
                    a_d  = a_i;
                    b_d  = b_i;
                    if (!op_i[1]) begin
                        state_d = MUL;
                    end else if (b_i == '0) begin
                        state_d = DONE;
                        hi_d    = a_i;
                        lo_d    = '1;
                        dz_d    = 1'b1;
                    end else begin
                        state_d = DIV_RUN;
                        cnt_d   = '0;
                        init_d  = 1'b1;
                    end
                end
            end
            MUL: begin
                hi_d    = prod[2*WIDTH-1:WIDTH];
                lo_d    = prod[WIDTH-1:0];
                state_d = DONE;
            end
            DIV_RUN: begin
                // First cycle only loads the dividend magnitude.
                if (init_q) begin
                    quo_d  = a_abs;
                    rem_d  = '0;
                    init_d = 1'b0;
                end else begin
                    quo_d = quo_nx;
                    rem_d = rem_nx;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        lo_d    = (a_neg ^ b_neg) ? -quo_nx : quo_nx;
                        hi_d    = a_neg ? -rem_nx : rem_nx;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                dz_d    = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (cancel_i) begin
            state_d = IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
            dz_d    = 1'b0;
            init_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            init_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            init_q  <= init_d;
            dz_q    <= dz_d;
        end
    end

    assign busy_o     = (state_q != IDLE);
    assign stall_o    = ~cancel_i & (((state_q == IDLE) & start_i) |
                                     (state_q == MUL) | (state_q == DIV_RUN));
    assign ready_o    = (state_q == DONE) & ~cancel_i;
    assign div_zero_o = dz_q & ready_o;
    assign hi_o       = hi_q;
    assign lo_o       = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Randomized self-checking bench for mdu_ctrl.
// Results come from a plain-arithmetic model of mult/div semantics.
module tb_mdu_ctrl;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         start_i = 1'b0;
    logic         cancel_i = 1'b0;
    logic [1:0]   op_i = '0;
    logic [W-1:0] a_i = '0;
    logic [W-1:0] b_i = '0;
    logic         stall_o, busy_o, ready_o, div_zero_o;
    logic [W-1:0] hi_o, lo_o;

    int checks = 0;
    int errors = 0;

    mdu_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .resetn(resetn), .start_i(start_i), .op_i(op_i),
        .a_i(a_i), .b_i(b_i), .cancel_i(cancel_i), .stall_o(stall_o),
        .busy_o(busy_o), .ready_o(ready_o), .hi_o(hi_o), .lo_o(lo_o),
        .div_zero_o(div_zero_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Returns {div_zero, hi, lo}.
    function automatic logic [64:0] model(input logic [1:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        longint      sa, sb, sp, sq, sr;
        logic [63:0] up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        model = '0;
        case (op)
            2'd0: begin
                sp = sa * sb;
                model = {1'b0, sp[63:0]};
            end
            2'd1: begin
                up = {32'b0, a} * {32'b0, b};
                model = {1'b0, up};
            end
            default: begin
                if (b == 0) begin
                    model = {1'b1, a, 32'hFFFF_FFFF};
                end else if (op == 2'd2) begin
                    sq = sa / sb;
                    sr = sa % sb;
                    model = {1'b0, sr[31:0], sq[31:0]};
                end else begin
                    model = {1'b0, a % b, a / b};
                end
            end
        endcase
    endfunction

    task automatic run_op(input string tag, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b);
        logic [64:0] exp;
        int lat, k;
        exp = model(op, a, b);
        lat = !op[1] ? 2 : (b == 0 ? 1 : 34);
        @(negedge clk);
        start_i = 1'b1;
        op_i = op;
        a_i = a;
        b_i = b;
        #1;
        check({tag, "_stall_T"}, 64'(stall_o), 64'd1);
        @(negedge clk);
        start_i = 1'b0;
        a_i = $urandom;
        b_i = $urandom;
        k = 1;
        while (!ready_o && k < 40) begin
            check({tag, "_stall_run"}, 64'(stall_o), 64'd1);
            @(negedge clk);
            k++;
        end
        check({tag, "_lat"}, 64'(k), 64'(lat));
        check({tag, "_hi"}, 64'(hi_o), 64'(exp[63:32]));
        check({tag, "_lo"}, 64'(lo_o), 64'(exp[31:0]));
        check({tag, "_dz"}, 64'(div_zero_o), 64'(exp[64]));
        check({tag, "_stall_done"}, 64'(stall_o), 64'd0);
        @(negedge clk);
        check({tag, "_ready_after"}, 64'(ready_o), 64'd0);
        check({tag, "_busy_after"}, 64'(busy_o), 64'd0);
        check({tag, "_hold"}, {32'(hi_o), 32'(lo_o)}, exp[63:0]);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: pick = 32'h8000_0000;
            1: pick = 32'hFFFF_FFFF;
            2: pick = 32'h0;
            3: pick = $urandom_range(0, 20);
            default: pick = $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] phi, plo;
        int rdy;
        #3;
        check("rst_hi", 64'(hi_o), 64'd0);
        check("rst_lo", 64'(lo_o), 64'd0);
        check("rst_flags", {60'd0, busy_o, ready_o, stall_o, div_zero_o}, 64'd0);
        @(negedge clk);
        resetn = 1'b1;

        run_op("mult_neg", 2'd0, 32'hFFFF_FFFD, 32'd5);
        run_op("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("div_neg", 2'd2, 32'd7, 32'hFFFF_FFFE);
        run_op("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("divu_16", 2'd3, 32'hFFFF_FFFF, 32'd16);
        run_op("divu_zero", 2'd3, 32'h1234, 32'd0);
        run_op("div_zero", 2'd2, 32'h8000_0000, 32'd0);

        // Cancel in the middle of a divide.
        phi = hi_o;
        plo = lo_o;
        @(negedge clk);
        start_i = 1'b1;
        op_i = 2'd3;
        a_i = 32'd1000;
        b_i = 32'd7;
        @(negedge clk);
        start_i = 1'b0;
        repeat (11) @(negedge clk);
        cancel_i = 1'b1;
        #1;
        check("cancel_stall", 64'(stall_o), 64'd0);
        check("cancel_ready", 64'(ready_o), 64'd0);
        @(negedge clk);
        cancel_i = 1'b0;
        check("cancel_busy", 64'(busy_o), 64'd0);
        rdy = 0;
        repeat (40) begin
            @(negedge clk);
            if (ready_o) rdy++;
        end
        check("cancel_no_ready", 64'(rdy), 64'd0);
        check("cancel_hold", {32'(hi_o), 32'(lo_o)}, {32'(phi), 32'(plo)});
        run_op("mult_after_cancel", 2'd0, 32'h0001_0000, 32'hFFFF_0000);

        // Start and cancel together: start is dropped.
        @(negedge clk);
        start_i = 1'b1;
        cancel_i = 1'b1;
        op_i = 2'd0;
        #1;
        check("startcancel_stall", 64'(stall_o), 64'd0);
        @(negedge clk);
        start_i = 1'b0;
        cancel_i = 1'b0;
        check("startcancel_busy", 64'(busy_o), 64'd0);

        // Asynchronous reset in the middle of a divide.
        @(negedge clk);
        start_i = 1'b1;
        op_i = 2'd2;
        a_i = 32'd12345;
        b_i = 32'd3;
        @(negedge clk);
        start_i = 1'b0;
        repeat (5) @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check("arst_hi", 64'(hi_o), 64'd0);
        check("arst_lo", 64'(lo_o), 64'd0);
        check("arst_flags", {60'd0, busy_o, ready_o, stall_o, div_zero_o}, 64'd0);
        @(negedge clk);
        resetn = 1'b1;

        for (int i = 0; i < 40; i++) begin
            run_op("rand", 2'($urandom_range(0, 3)), pick(), pick());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Multi-cycle multiply/divide sequencer in the Execute stage. Feeds HI/LO results toward the HILO write path.
- Latches operands of mult/multu/div/divu and runs an iterative radix-2 divider or a registered multiplier.
- Asserts a stall request the hazard unit ORs into stallF/stallD/stallE.
- Presents a one-cycle result strobe with HI/LO when done. Supports cancel on pipeline flush.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.

Ports:
- clk  input  1  rising-edge clock
- resetn  input  1  asynchronous active-low reset
- start_i  input  1  valid mult/div op present in Execute
- op_i  input  2  00 mult, 01 multu, 10 div, 11 divu
- a_i  input  WIDTH  rs operand (forwarded value)
- b_i  input  WIDTH  rt operand (forwarded value)
- cancel_i  input  1  flush of Execute; aborts the operation in flight
- stall_o  output  1  pipeline stall request
- busy_o  output  1  state is not IDLE
- ready_o  output  1  one-cycle strobe: hi_o/lo_o valid
- hi_o  output  WIDTH  HI result (product high half or remainder)
- lo_o  output  WIDTH  LO result (product low half or quotient)
- div_zero_o  output  1  with ready_o: divisor was zero

Behaviour:
- Reset (resetn=0, async): state=IDLE, counter=0, hi_o=lo_o=0, ready_o=div_zero_o=0, busy_o=0.
- FSM states: IDLE, MUL, DIV_RUN, DONE.
- IDLE & start_i & !cancel_i:
  - latch op, a_i, b_i.
  - mult/multu → MUL.
  - div/divu with b_i≠0 → DIV_RUN, counter=0.
  - div/divu with b_i==0 → DONE, hi_o=a_i, lo_o={WIDTH{1}}, div_zero_o=1.
- MUL (1 cycle):
  - signed or unsigned 2·WIDTH product of the latched operands.
  - hi_o=product[2W-1:W], lo_o=product[W-1:0] → DONE.
  - Mult latency: start sampled at edge T, ready_o high in cycle T+2.
- DIV_RUN:
  - Signed ops first take absolute values of dividend and divisor.
  - Restoring division, one quotient bit per cycle, WIDTH cycles (counter 0..WIDTH-1).
  - When counter==WIDTH-1 → DONE.
  - Sign fixup on final write: quotient negated if operand signs differ; remainder takes the dividend's sign.
  - Signed INT_MIN/-1 → lo=0x80000000, hi=0 with no special case; magnitude wraps naturally.
  - Div latency: ready_o in cycle T+WIDTH+2.
- DONE: ready_o=1 for exactly this cycle. start_i is ignored here because it is the same instruction. Next state is IDLE.
- stall_o = (IDLE & start_i & !cancel_i) | MUL | DIV_RUN, with cancel_i forcing 0. stall_o=0 in DONE so the instruction advances with the result.
- busy_o = (state≠IDLE).
- hi_o/lo_o hold their value after DONE until the next result write. div_zero_o clears on leaving DONE.
- cancel_i in any state:
  - next state IDLE, no ready_o, hi_o/lo_o unchanged.
  - cancel_i and start_i in the same IDLE cycle: start is dropped.
- Reset mid-operation: immediate return to reset values; no partial result is visible.
- Operands are sampled only on the IDLE→busy transition. Changes on a_i/b_i afterwards are ignored.

Test Plan:
- mult a=0xFFFFFFFD (-3), b=5 → after 2 cycles ready_o=1, hi=0xFFFFFFFF, lo=0xFFFFFFF1; stall_o high cycles T, T+1, low at T+2.
- multu a=0xFFFFFFFF, b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- div a=7, b=0xFFFFFFFE (-2) → lo=0xFFFFFFFD, hi=1, ready_o exactly at T+34, stall_o high for 34 cycles.
- div a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0; divu a=0xFFFFFFFF, b=16 → lo=0x0FFFFFFF, hi=0xF.
- divu b=0, a=0x1234 → next cycle ready_o=1, div_zero_o=1, hi=0x1234, lo=0xFFFFFFFF.
- Cancel/reset:
  - div started, cancel_i at iteration 10 → IDLE next cycle, no ready_o, hi/lo keep prior values; new mult then completes correctly.
  - resetn low mid-div → all outputs 0 asynchronously.
